ps2_key_decoder: RTL and testbench

//  Consumer stage behind the PS/2 receiver FIFO: pops scan-code bytes with the ready/nextdata_n handshake.

---
 rtl/ps2_key_decoder.sv | 185 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops PS/2 scan bytes, resolves E0/F0 prefixes, emits key events with ASCII.
// Define KBD_SHIFT_EN to add shift/caps-lock tracking and the shifted ASCII map.
module ps2_key_decoder #(
  parameter int COUNT_W        = 8,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               ready,
  input  logic [7:0]         data,
  output logic               nextdata_n,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_make,
  output logic               key_repeat,
  output logic [7:0]         key_ascii,
  output logic [7:0]         last_ascii,
  output logic               key_down,
  output logic [COUNT_W-1:0] key_count,
  output logic               caps_lock
);
  localparam int TW = $clog2(PREFIX_TIMEOUT);
  typedef enum logic [1:0] {IDLE, ACK, DECODE} state_t;
  state_t          r_state;
  logic [7:0]      r_byte;
  logic            r_ext;
  logic            r_brk;
  logic [8:0]      r_held;
  logic [TW-1:0]   r_tmo;
  logic [8:0]      w_key;
  logic            w_repeat;
  logic            w_shift;
  logic            w_letter;
  logic [7:0]      w_lc;
  logic [7:0]      w_uc;
  logic [7:0]      w_ascii;
`ifdef KBD_SHIFT_EN
  logic            r_lsh;
  logic            r_rsh;
  assign w_shift = r_lsh | r_rsh;
`else
  assign w_shift   = 1'b0;
  assign caps_lock = 1'b0;
`endif
  assign w_key    = {r_ext, r_byte};
  assign w_repeat = (w_key == r_held) && key_down;
  // w_lc is the unshifted glyph, w_uc the shifted one for non-letter keys
  always_comb begin
    w_lc = 8'h00;
    w_uc = 8'h00;
    case (r_byte)
      8'h1C: w_lc = "a";
      8'h32: w_lc = "b";
      8'h21: w_lc = "c";
      8'h23: w_lc = "d";
      8'h24: w_lc = "e";
      8'h2B: w_lc = "f";
      8'h34: w_lc = "g";
      8'h33: w_lc = "h";
      8'h43: w_lc = "i";
      8'h3B: w_lc = "j";
      8'h42: w_lc = "k";
      8'h4B: w_lc = "l";
      8'h3A: w_lc = "m";
      8'h31: w_lc = "n";
      8'h44: w_lc = "o";
      8'h4D: w_lc = "p";
      8'h15: w_lc = "q";
      8'h2D: w_lc = "r";
      8'h1B: w_lc = "s";
      8'h2C: w_lc = "t";
      8'h3C: w_lc = "u";
      8'h2A: w_lc = "v";
      8'h1D: w_lc = "w";
      8'h22: w_lc = "x";
      8'h35: w_lc = "y";
      8'h1A: w_lc = "z";
      8'h45: begin w_lc = "0"; w_uc = ")"; end
      8'h16: begin w_lc = "1"; w_uc = "!"; end
      8'h1E: begin w_lc = "2"; w_uc = "@"; end
      8'h26: begin w_lc = "3"; w_uc = "#"; end
      8'h25: begin w_lc = "4"; w_uc = "$"; end
      8'h2E: begin w_lc = "5"; w_uc = "%"; end
      8'h36: begin w_lc = "6"; w_uc = "^"; end
      8'h3D: begin w_lc = "7"; w_uc = "&"; end
      8'h3E: begin w_lc = "8"; w_uc = "*"; end
      8'h46: begin w_lc = "9"; w_uc = "("; end
      8'h4E: begin w_lc = "-"; w_uc = "_"; end
      8'h55: begin w_lc = "="; w_uc = "+"; end
      8'h29: w_lc = 8'h20;
      8'h5A: w_lc = 8'h0D;
      8'h66: w_lc = 8'h08;
      8'h0D: w_lc = 8'h09;
      default: w_lc = 8'h00;
    endcase
  end
  assign w_letter = (w_lc >= 8'h61) && (w_lc <= 8'h7A);
  assign w_ascii  = r_ext ? 8'h00 :
                    w_letter ? ((w_shift ^ caps_lock) ? w_lc - 8'h20 : w_lc) :
                    (w_shift && w_uc != 8'h00) ? w_uc : w_lc;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= IDLE;
      r_byte     <= 8'h00;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_held     <= 9'h000;
      r_tmo      <= '0;
      nextdata_n <= 1'b1;
      key_valid  <= 1'b0;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_make   <= 1'b0;
      key_repeat <= 1'b0;
      key_ascii  <= 8'h00;
      last_ascii <= 8'h00;
      key_down   <= 1'b0;
      key_count  <= '0;
`ifdef KBD_SHIFT_EN
      r_lsh      <= 1'b0;
      r_rsh      <= 1'b0;
      caps_lock  <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ready) begin
            r_byte     <= data;
            nextdata_n <= 1'b0;
            r_tmo      <= '0;
            r_state    <= ACK;
          end else if (r_ext | r_brk) begin
            // a stale prefix is dropped after PREFIX_TIMEOUT starved idle cycles
            if (r_tmo == TW'(PREFIX_TIMEOUT - 1)) begin
              r_ext <= 1'b0;
              r_brk <= 1'b0;
              r_tmo <= '0;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
        end
        ACK: begin
          nextdata_n <= 1'b1;
          r_state    <= DECODE;
        end
        DECODE: begin
          r_state <= IDLE;
          if (r_byte == 8'hE0) begin
            r_ext <= 1'b1;
          end else if (r_byte == 8'hF0) begin
            r_brk <= 1'b1;
          end else begin
            key_valid  <= 1'b1;
            key_code   <= r_byte;
            key_ext    <= r_ext;
            key_make   <= ~r_brk;
            key_repeat <= ~r_brk & w_repeat;
            key_ascii  <= w_ascii;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            if (!r_brk) begin
              if (!w_repeat) begin
                r_held     <= w_key;
                key_down   <= 1'b1;
                key_count  <= key_count + COUNT_W'(1);
                last_ascii <= w_ascii;
              end
            end else if (w_key == r_held) begin
              key_down <= 1'b0;
            end
`ifdef KBD_SHIFT_EN
            if (!r_ext && r_byte == 8'h12) r_lsh <= ~r_brk;
            if (!r_ext && r_byte == 8'h59) r_rsh <= ~r_brk;
            if (!r_ext && r_byte == 8'h58 && !r_brk && !w_repeat) caps_lock <= ~caps_lock;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed scan-code sequences through a FIFO model, checked against hand-computed events.
module tb_ps2_key_decoder;
  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       nextdata_n, key_valid, key_ext, key_make, key_repeat, key_down, caps_lock;
  logic [7:0] key_code, key_ascii, last_ascii, key_count;

  ps2_key_decoder #(.COUNT_W(8), .PREFIX_TIMEOUT(16)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .nextdata_n(nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext), .key_make(key_make),
    .key_repeat(key_repeat), .key_ascii(key_ascii), .last_ascii(last_ascii),
    .key_down(key_down), .key_count(key_count), .caps_lock(caps_lock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       make;
    logic       rep;
    logic [7:0] ascii;
    logic [7:0] last;
    logic       down;
    logic [7:0] cnt;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_pushed = 0;
  int         n_low = 0;
  int         hs_viol = 0;
  logic       prev_low = 1'b0;
  int         base;
  logic       found;
  logic [7:0] c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // monitor: handshake sanity and event capture, sampled mid-cycle
  always @(negedge clk) begin
    if (!nextdata_n) begin
      n_low <= n_low + 1;
      if (!ready || prev_low) hs_viol <= hs_viol + 1;
    end
    prev_low <= !nextdata_n;
    if (key_valid)
      ev_q.push_back({key_code, key_ext, key_make, key_repeat, key_ascii, last_ascii, key_down, key_count});
  end

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    n_pushed++;
  endtask

  task automatic drain();
    int n = 0;
    ready = (q.size() != 0);
    data  = ready ? q[0] : 8'h00;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      if (!nextdata_n) begin
        void'(q.pop_front());
        ready = (q.size() != 0);
        data  = ready ? q[0] : 8'h00;
      end
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    q.delete();
    ready = 1'b0;
    data  = 8'h00;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1 clrn = 1'b0;
    #3;
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_count", key_count, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_last_ascii", last_ascii, 0);
    chk("rst_caps", caps_lock, 0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    // make then break of A
    base = ev_q.size();
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    chk("t1_nev", ev_q.size() - base, 2);
    chk("t1_make_code", ev_q[base].code, 8'h1C);
    chk("t1_make_flag", ev_q[base].make, 1);
    chk("t1_make_ascii", ev_q[base].ascii, 8'h61);
    chk("t1_make_cnt", ev_q[base].cnt, 1);
    chk("t1_make_down", ev_q[base].down, 1);
    chk("t1_brk_flag", ev_q[base+1].make, 0);
    chk("t1_brk_down", ev_q[base+1].down, 0);

    // typematic repeat
    do_reset();
    base = ev_q.size();
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain();
    chk("t2_nev", ev_q.size() - base, 3);
    chk("t2_rep0", ev_q[base].rep, 0);
    chk("t2_rep1", ev_q[base+1].rep, 1);
    chk("t2_rep2", ev_q[base+2].rep, 1);
    chk("t2_cnt", key_count, 1);
    chk("t2_last", last_ascii, 8'h61);

    // extended make/break
    do_reset();
    base = ev_q.size();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    chk("t3_nev", ev_q.size() - base, 2);
    chk("t3_make_ext", ev_q[base].ext, 1);
    chk("t3_make_code", ev_q[base].code, 8'h75);
    chk("t3_make_ascii", ev_q[base].ascii, 8'h00);
    chk("t3_make_down", ev_q[base].down, 1);
    chk("t3_brk_ext", ev_q[base+1].ext, 1);
    chk("t3_brk_make", ev_q[base+1].make, 0);
    chk("t3_brk_down", ev_q[base+1].down, 0);

    // shift / caps lock
    do_reset();
    base = ev_q.size();
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0);
    push(8'h12); push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
    drain();
    chk("t4_nev", ev_q.size() - base, 7);
`ifdef KBD_SHIFT_EN
    chk("t4_shift_ascii", ev_q[base+1].ascii, 8'h41);
    chk("t4_caps_ascii", ev_q[base+6].ascii, 8'h41);
    chk("t4_caps", caps_lock, 1);
`else
    chk("t4_shift_ascii", ev_q[base+1].ascii, 8'h61);
    chk("t4_caps_ascii", ev_q[base+6].ascii, 8'h61);
    chk("t4_caps", caps_lock, 0);
`endif
    chk("t4_caps_key_ascii", ev_q[base+4].ascii, 8'h00);

    // prefix timeout vs prompt follow-up
    do_reset();
    base = ev_q.size();
    push(8'hF0); push(8'h1C);
    drain();
    chk("t5_prompt_brk", ev_q[base].make, 0);
    base = ev_q.size();
    push(8'hF0);
    drain();
    repeat (20) @(negedge clk);
    push(8'h1C);
    drain();
    chk("t5_nev", ev_q.size() - base, 1);
    chk("t5_timeout_make", ev_q[base].make, 1);

    // async reset in the middle of the pop strobe
    do_reset();
    push(8'h1C);
    drain();
    q.push_back(8'h2D);
    ready = 1'b1;
    data  = 8'h2D;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1;
      if (!nextdata_n) found = 1'b1;
    end
    chk("t6_ack_seen", found, 1);
    clrn = 1'b0;
    q.delete();
    ready = 1'b0;
    data  = 8'h00;
    #1;
    chk("t6_nextdata_n", nextdata_n, 1);
    chk("t6_key_count", key_count, 0);
    chk("t6_last_ascii", last_ascii, 0);
    chk("t6_key_down", key_down, 0);
    chk("t6_key_code", key_code, 0);
    chk("t6_key_make", key_make, 0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);

    // key_count wrap over 256 distinct make/break pairs
    do_reset();
    for (int i = 0; i < 256; i++) begin
      c = {1'b0, i[6:0]} + 8'd1;
      if (i[7]) push(8'hE0);
      push(c);
      if (i[7]) push(8'hE0);
      push(8'hF0);
      push(c);
      drain();
      if (i == 254) chk("t7_count_255", key_count, 8'hFF);
    end
    chk("t7_count_wrap", key_count, 0);
    chk("t7_key_down", key_down, 0);

    chk("hs_violations", hs_viol, 0);
    chk("hs_pop_count", n_low, n_pushed);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
